// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta core pipeline control.
//   pipe_ctrl_state_t : pipeline control FSM encoding (exported on ctrl_state_o)
//   pc_sel_t          : PC source select
//   pipe_reg_ctl_t    : stall/flush pair for one pipeline register
//   pipe_ctl_t        : full control bundle produced each cycle
package beta_pkg;

    localparam int unsigned DataWidth    = 32;
    localparam int unsigned DefPenWidth  = 2;
    localparam int unsigned RegAddrWidth = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENALTY = 2'd1,
        DRAIN   = 2'd2,
        TRAP    = 2'd3
    } pipe_ctrl_state_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_TRAP   = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_reg_ctl_t;

    typedef struct packed {
        logic          pc_stall;
        pipe_reg_ctl_t ifd;
        pipe_reg_ctl_t dex;
        pipe_reg_ctl_t exm;
        pipe_reg_ctl_t mwb;
        pc_sel_t       pc_sel;
        logic          trap_taken;
    } pipe_ctl_t;

    // Freeze PC, IF/DEC and DEC/EXE; used by every "hold the front end" case.
    function automatic pipe_ctl_t hold_front(input pipe_ctl_t ctl);
        pipe_ctl_t r;
        r           = ctl;
        r.pc_stall  = 1'b1;
        r.ifd.stall = 1'b1;
        r.dex.stall = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/beta_hazard_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in DEC reads a register that a load currently in
// EXE will write; x0 is never a hazard since it is hard-wired to zero.
//   dec_rs1_addr_i/dec_rs2_addr_i : source registers of the DEC instruction
//   dec_rs1_used_i/dec_rs2_used_i : which sources the DEC instruction reads
//   exe_valid_i, exe_rd_addr_i, exe_is_load_i : EXE instruction info
//   load_use_c                    : combinational hazard flag
module beta_hazard_detect
    import beta_pkg::*;
(
    input  logic [RegAddrWidth-1:0] dec_rs1_addr_i,
    input  logic [RegAddrWidth-1:0] dec_rs2_addr_i,
    input  logic                    dec_rs1_used_i,
    input  logic                    dec_rs2_used_i,
    input  logic                    exe_valid_i,
    input  logic [RegAddrWidth-1:0] exe_rd_addr_i,
    input  logic                    exe_is_load_i,
    output logic                    load_use_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;
    logic load_wr_c;

    // Source/destination match, then qualify with a real load writing non-x0.
    always_comb begin
        rs1_hit_c  = dec_rs1_used_i && (dec_rs1_addr_i == exe_rd_addr_i);
        rs2_hit_c  = dec_rs2_used_i && (dec_rs2_addr_i == exe_rd_addr_i);
        load_wr_c  = exe_valid_i && exe_is_load_i && (exe_rd_addr_i != '0);
        load_use_c = load_wr_c && (rs1_hit_c || rs2_hit_c);
    end

endmodule

// File: rtl/beta_pipe_ctrl.sv
// Global pipeline control for the 5-stage Beta core.
// Produces stall/flush for IF/DEC, DEC/EXE, EXE/MEM and MEM/WB plus the PC
// source select. Outputs are combinational from the FSM state, the penalty
// counter and the current inputs; only state, pen_cnt and irq_pend are flops.
// All outputs are forced low while rstn_i is asserted.
//   clk_i, rstn_i              : clock, async active-low reset
//   dec_*                      : source operand info of the DEC instruction
//   exe_valid_i/rd/is_load     : EXE instruction info for load-use detection
//   exe_busy_i, mem_busy_i     : multi-cycle EXE / outstanding MEM access
//   exe_branch_taken_i         : taken branch/jump resolved in EXE
//   exe_penality_i             : extra fetch-bubble cycles after the branch
//   exe_trap_i, irq_i          : illegal instruction in EXE, level interrupt
//   pc_stall_o, *_stall_o/_flush_o : pipeline register control
//   pc_sel_o                   : PC_SEQ / PC_BRANCH / PC_TRAP
//   trap_taken_o               : one-cycle pulse on redirect to trap vector
//   ctrl_state_o               : current FSM state
module beta_pipe_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned PenWidth = DefPenWidth
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [RegAddrWidth-1:0] dec_rs1_addr_i,
    input  logic [RegAddrWidth-1:0] dec_rs2_addr_i,
    input  logic                    dec_rs1_used_i,
    input  logic                    dec_rs2_used_i,
    input  logic                    exe_valid_i,
    input  logic [RegAddrWidth-1:0] exe_rd_addr_i,
    input  logic                    exe_is_load_i,
    input  logic                    exe_busy_i,
    input  logic                    mem_busy_i,
    input  logic                    exe_branch_taken_i,
    input  logic [PenWidth-1:0]     exe_penality_i,
    input  logic                    exe_trap_i,
    input  logic                    irq_i,
    output logic                    pc_stall_o,
    output logic                    ifd_stall_o,
    output logic                    ifd_flush_o,
    output logic                    dex_stall_o,
    output logic                    dex_flush_o,
    output logic                    exm_stall_o,
    output logic                    exm_flush_o,
    output logic                    mwb_stall_o,
    output logic                    mwb_flush_o,
    output logic [1:0]              pc_sel_o,
    output logic                    trap_taken_o,
    output logic [1:0]              ctrl_state_o
);

    pipe_ctrl_state_t    state_q;
    pipe_ctrl_state_t    state_d;
    logic [PenWidth-1:0] pen_cnt_q;
    logic [PenWidth-1:0] pen_cnt_d;
    logic                irq_pend_q;
    logic                irq_pend_d;

    logic      load_use_c;
    logic      exe_trap_c;
    logic      irq_any_c;
    logic      irq_defer_c;
    logic      trap_run_c;
    logic      trap_pen_c;
    pipe_ctl_t ctl_c;

    beta_hazard_detect u_hazard (
        .dec_rs1_addr_i (dec_rs1_addr_i),
        .dec_rs2_addr_i (dec_rs2_addr_i),
        .dec_rs1_used_i (dec_rs1_used_i),
        .dec_rs2_used_i (dec_rs2_used_i),
        .exe_valid_i    (exe_valid_i),
        .exe_rd_addr_i  (exe_rd_addr_i),
        .exe_is_load_i  (exe_is_load_i),
        .load_use_c     (load_use_c)
    );

    // Trap sources. An interrupt coinciding with a branch that would actually
    // be served this cycle yields to the branch and is taken from irq_pend on
    // the following RUN cycle; an illegal instruction always wins.
    always_comb begin
        exe_trap_c  = exe_valid_i && exe_trap_i;
        irq_any_c   = irq_pend_q || irq_i;
        irq_defer_c = exe_branch_taken_i && !mem_busy_i && !exe_busy_i;
        trap_run_c  = exe_trap_c || (irq_any_c && !irq_defer_c);
        trap_pen_c  = exe_trap_c || irq_any_c;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= RUN;
            pen_cnt_q  <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pen_cnt_q  <= pen_cnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        pen_cnt_d  = pen_cnt_q;
        irq_pend_d = irq_pend_q;
        ctl_c      = '0;

        unique case (state_q)
            RUN: begin
                irq_pend_d = irq_pend_q || irq_i;
                if (trap_run_c) begin
                    // Trapping instruction must not reach MEM; older MEM op may still drain.
                    ctl_c           = hold_front(ctl_c);
                    ctl_c.exm.flush = 1'b1;
                    state_d         = mem_busy_i ? DRAIN : TRAP;
                end else if (mem_busy_i) begin
                    ctl_c           = hold_front(ctl_c);
                    ctl_c.exm.stall = 1'b1;
                    ctl_c.mwb.flush = 1'b1;
                end else if (exe_busy_i) begin
                    ctl_c           = hold_front(ctl_c);
                    ctl_c.exm.flush = 1'b1;
                end else if (exe_branch_taken_i) begin
                    ctl_c.pc_sel    = PC_BRANCH;
                    ctl_c.ifd.flush = 1'b1;
                    ctl_c.dex.flush = 1'b1;
                    if (exe_penality_i != '0) begin
                        pen_cnt_d = exe_penality_i;
                        state_d   = PENALTY;
                    end
                end else if (load_use_c) begin
                    ctl_c.pc_stall  = 1'b1;
                    ctl_c.ifd.stall = 1'b1;
                    ctl_c.dex.flush = 1'b1;
                end
            end

            PENALTY: begin
                irq_pend_d = irq_pend_q || irq_i;
                if (trap_pen_c) begin
                    // Remaining branch bubbles are abandoned in favour of the trap.
                    ctl_c           = hold_front(ctl_c);
                    ctl_c.exm.flush = 1'b1;
                    pen_cnt_d       = '0;
                    state_d         = mem_busy_i ? DRAIN : TRAP;
                end else begin
                    ctl_c.ifd.flush = 1'b1;
                    pen_cnt_d       = pen_cnt_q - PenWidth'(1);
                    if (pen_cnt_q == PenWidth'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            DRAIN: begin
                // Front end frozen until the outstanding memory access retires.
                ctl_c           = hold_front(ctl_c);
                ctl_c.exm.stall = 1'b1;
                if (mem_busy_i) begin
                    ctl_c.mwb.flush = 1'b1;
                end else begin
                    state_d = TRAP;
                end
            end

            TRAP: begin
                ctl_c.pc_sel     = PC_TRAP;
                ctl_c.trap_taken = 1'b1;
                ctl_c.ifd.flush  = 1'b1;
                ctl_c.dex.flush  = 1'b1;
                ctl_c.exm.flush  = 1'b1;
                irq_pend_d       = 1'b0;
                state_d          = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        if (!rstn_i) begin
            ctl_c = '0;
        end
    end

    assign pc_stall_o   = ctl_c.pc_stall;
    assign ifd_stall_o  = ctl_c.ifd.stall;
    assign ifd_flush_o  = ctl_c.ifd.flush;
    assign dex_stall_o  = ctl_c.dex.stall;
    assign dex_flush_o  = ctl_c.dex.flush;
    assign exm_stall_o  = ctl_c.exm.stall;
    assign exm_flush_o  = ctl_c.exm.flush;
    assign mwb_stall_o  = ctl_c.mwb.stall;
    assign mwb_flush_o  = ctl_c.mwb.flush;
    assign pc_sel_o     = ctl_c.pc_sel;
    assign trap_taken_o = ctl_c.trap_taken;
    assign ctrl_state_o = state_q;

endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// Directed bench for beta_pipe_ctrl. Inputs change on the falling edge and
// outputs are compared 1 time unit later, well away from the rising edge.
module tb_beta_pipe_ctrl;

    logic       clk_i;
    logic       rstn_i;
    logic [4:0] dec_rs1_addr_i;
    logic [4:0] dec_rs2_addr_i;
    logic       dec_rs1_used_i;
    logic       dec_rs2_used_i;
    logic       exe_valid_i;
    logic [4:0] exe_rd_addr_i;
    logic       exe_is_load_i;
    logic       exe_busy_i;
    logic       mem_busy_i;
    logic       exe_branch_taken_i;
    logic [1:0] exe_penality_i;
    logic       exe_trap_i;
    logic       irq_i;
    logic       pc_stall_o;
    logic       ifd_stall_o;
    logic       ifd_flush_o;
    logic       dex_stall_o;
    logic       dex_flush_o;
    logic       exm_stall_o;
    logic       exm_flush_o;
    logic       mwb_stall_o;
    logic       mwb_flush_o;
    logic [1:0] pc_sel_o;
    logic       trap_taken_o;
    logic [1:0] ctrl_state_o;

    int checks;
    int failures;

    beta_pipe_ctrl #(.PenWidth(2)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .dec_rs1_addr_i     (dec_rs1_addr_i),
        .dec_rs2_addr_i     (dec_rs2_addr_i),
        .dec_rs1_used_i     (dec_rs1_used_i),
        .dec_rs2_used_i     (dec_rs2_used_i),
        .exe_valid_i        (exe_valid_i),
        .exe_rd_addr_i      (exe_rd_addr_i),
        .exe_is_load_i      (exe_is_load_i),
        .exe_busy_i         (exe_busy_i),
        .mem_busy_i         (mem_busy_i),
        .exe_branch_taken_i (exe_branch_taken_i),
        .exe_penality_i     (exe_penality_i),
        .exe_trap_i         (exe_trap_i),
        .irq_i              (irq_i),
        .pc_stall_o         (pc_stall_o),
        .ifd_stall_o        (ifd_stall_o),
        .ifd_flush_o        (ifd_flush_o),
        .dex_stall_o        (dex_stall_o),
        .dex_flush_o        (dex_flush_o),
        .exm_stall_o        (exm_stall_o),
        .exm_flush_o        (exm_flush_o),
        .mwb_stall_o        (mwb_stall_o),
        .mwb_flush_o        (mwb_flush_o),
        .pc_sel_o           (pc_sel_o),
        .trap_taken_o       (trap_taken_o),
        .ctrl_state_o       (ctrl_state_o)
    );

    // Observed bundle:
    // [13] pc_stall [12] ifd_stall [11] ifd_flush [10] dex_stall [9] dex_flush
    // [8] exm_stall [7] exm_flush [6] mwb_stall [5] mwb_flush [4:3] pc_sel
    // [2] trap_taken [1:0] ctrl_state
    logic [13:0] obs;
    assign obs = {pc_stall_o, ifd_stall_o, ifd_flush_o, dex_stall_o, dex_flush_o,
                  exm_stall_o, exm_flush_o, mwb_stall_o, mwb_flush_o,
                  pc_sel_o, trap_taken_o, ctrl_state_o};

    localparam logic [13:0] B_PCS    = 14'h2000;
    localparam logic [13:0] B_IFDS   = 14'h1000;
    localparam logic [13:0] B_IFDF   = 14'h0800;
    localparam logic [13:0] B_DEXS   = 14'h0400;
    localparam logic [13:0] B_DEXF   = 14'h0200;
    localparam logic [13:0] B_EXMS   = 14'h0100;
    localparam logic [13:0] B_EXMF   = 14'h0080;
    localparam logic [13:0] B_MWBF   = 14'h0020;
    localparam logic [13:0] SEL_BR   = 14'h0008;
    localparam logic [13:0] SEL_TRAP = 14'h0010;
    localparam logic [13:0] B_TT     = 14'h0004;
    localparam logic [13:0] ST_PEN   = 14'h0001;
    localparam logic [13:0] ST_DRAIN = 14'h0002;
    localparam logic [13:0] ST_TRAP  = 14'h0003;

    localparam logic [13:0] E_IDLE    = 14'h0000;
    localparam logic [13:0] E_LOADUSE = B_PCS | B_IFDS | B_DEXF;
    localparam logic [13:0] E_EXEBUSY = B_PCS | B_IFDS | B_DEXS | B_EXMF;
    localparam logic [13:0] E_MEMBUSY = B_PCS | B_IFDS | B_DEXS | B_EXMS | B_MWBF;
    localparam logic [13:0] E_DETECT  = B_PCS | B_IFDS | B_DEXS | B_EXMF;
    localparam logic [13:0] E_BRANCH  = SEL_BR | B_IFDF | B_DEXF;
    localparam logic [13:0] E_PEN     = B_IFDF | ST_PEN;
    localparam logic [13:0] E_DRAINB  = B_PCS | B_IFDS | B_DEXS | B_EXMS | B_MWBF | ST_DRAIN;
    localparam logic [13:0] E_DRAINX  = B_PCS | B_IFDS | B_DEXS | B_EXMS | ST_DRAIN;
    localparam logic [13:0] E_TRAP    = SEL_TRAP | B_TT | B_IFDF | B_DEXF | B_EXMF | ST_TRAP;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        dec_rs1_addr_i     = '0;
        dec_rs2_addr_i     = '0;
        dec_rs1_used_i     = 1'b0;
        dec_rs2_used_i     = 1'b0;
        exe_valid_i        = 1'b0;
        exe_rd_addr_i      = '0;
        exe_is_load_i      = 1'b0;
        exe_busy_i         = 1'b0;
        mem_busy_i         = 1'b0;
        exe_branch_taken_i = 1'b0;
        exe_penality_i     = '0;
        exe_trap_i         = 1'b0;
        irq_i              = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        exe_valid_i    = 1'b1;
        exe_is_load_i  = 1'b1;
        exe_rd_addr_i  = rd;
        dec_rs1_addr_i = rs1;
        dec_rs1_used_i = u1;
        dec_rs2_addr_i = rs2;
        dec_rs2_used_i = u2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clr_inputs();
        rstn_i = 1'b0;

        // Reset: outputs held low even with a live load-use pattern on the inputs.
        @(negedge clk_i); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk_i); #1 check_eq("reset_gate", obs, E_IDLE);
        @(negedge clk_i); clr_inputs(); rstn_i = 1'b1;
        #1 check_eq("after_rst", obs, E_IDLE);

        // Load-use on rs1, then bubble in EXE.
        @(negedge clk_i); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 check_eq("lu_rs1", obs, E_LOADUSE);
        @(negedge clk_i); clr_inputs();
        #1 check_eq("lu_resolved", obs, E_IDLE);
        @(negedge clk_i); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 check_eq("lu_rd0", obs, E_IDLE);
        @(negedge clk_i); set_load(5'd9, 5'd1, 1'b1, 5'd9, 1'b0);
        #1 check_eq("lu_rs2_unused", obs, E_IDLE);
        @(negedge clk_i); set_load(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
        #1 check_eq("lu_rs2", obs, E_LOADUSE);

        // Taken branch with 2 penalty cycles.
        @(negedge clk_i); clr_inputs(); exe_branch_taken_i = 1'b1; exe_penality_i = 2'd2;
        #1 check_eq("br_cyc0", obs, E_BRANCH);
        @(negedge clk_i); clr_inputs();
        #1 check_eq("br_pen1", obs, E_PEN);
        @(negedge clk_i);
        #1 check_eq("br_pen2", obs, E_PEN);
        @(negedge clk_i);
        #1 check_eq("br_done", obs, E_IDLE);

        // Priorities: exe_busy over branch, mem_busy over load-use.
        @(negedge clk_i); exe_busy_i = 1'b1; exe_branch_taken_i = 1'b1; exe_penality_i = 2'd1;
        #1 check_eq("exebusy_br", obs, E_EXEBUSY);
        @(negedge clk_i); clr_inputs(); set_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); mem_busy_i = 1'b1;
        #1 check_eq("membusy_lu", obs, E_MEMBUSY);

        // Illegal instruction while memory busy: detect, drain, trap.
        @(negedge clk_i); clr_inputs(); exe_valid_i = 1'b1; exe_trap_i = 1'b1; mem_busy_i = 1'b1;
        #1 check_eq("trap_detect", obs, E_DETECT);
        @(negedge clk_i); clr_inputs(); mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("drain_busy", obs, E_DRAINB);
            @(negedge clk_i);
        end
        mem_busy_i = 1'b0;
        #1 check_eq("drain_exit", obs, E_DRAINX);
        @(negedge clk_i);
        #1 check_eq("trap_pulse", obs, E_TRAP);
        @(negedge clk_i);
        #1 check_eq("trap_back_run", obs, E_IDLE);

        // Trap and branch in the same cycle: branch discarded.
        @(negedge clk_i); exe_valid_i = 1'b1; exe_trap_i = 1'b1;
        exe_branch_taken_i = 1'b1; exe_penality_i = 2'd1;
        #1 check_eq("trapbr_detect", obs, E_DETECT);
        @(negedge clk_i); clr_inputs();
        #1 check_eq("trapbr_trap", obs, E_TRAP);
        @(negedge clk_i);
        #1 check_eq("trapbr_run", obs, E_IDLE);

        // IRQ pulse with a zero-penalty branch: branch first, trap two cycles on.
        @(negedge clk_i); irq_i = 1'b1; exe_branch_taken_i = 1'b1; exe_penality_i = 2'd0;
        #1 check_eq("irqbr_branch", obs, E_BRANCH);
        @(negedge clk_i); clr_inputs();
        #1 check_eq("irqbr_detect", obs, E_DETECT);
        @(negedge clk_i);
        #1 check_eq("irqbr_trap", obs, E_TRAP);
        @(negedge clk_i);
        #1 check_eq("irqbr_cleared", obs, E_IDLE);

        // IRQ during PENALTY abandons the remaining bubbles.
        @(negedge clk_i); exe_branch_taken_i = 1'b1; exe_penality_i = 2'd3;
        #1 check_eq("penirq_br", obs, E_BRANCH);
        @(negedge clk_i); clr_inputs(); irq_i = 1'b1;
        #1 check_eq("penirq_detect", obs, E_DETECT | ST_PEN);
        @(negedge clk_i); irq_i = 1'b0;
        #1 check_eq("penirq_trap", obs, E_TRAP);
        @(negedge clk_i);
        #1 check_eq("penirq_run", obs, E_IDLE);

        // Reset asserted in PENALTY with pen_cnt=2.
        @(negedge clk_i); exe_branch_taken_i = 1'b1; exe_penality_i = 2'd2;
        #1 check_eq("rstpen_br", obs, E_BRANCH);
        @(negedge clk_i); clr_inputs();
        #1 check_eq("rstpen_pen", obs, E_PEN);
        #1 rstn_i = 1'b0;
        #1 check_eq("rstpen_held", obs, E_IDLE);
        @(negedge clk_i); rstn_i = 1'b1;
        #1 check_eq("rstpen_release", obs, E_IDLE);
        @(negedge clk_i);
        #1 check_eq("rstpen_run", obs, E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
